// File: rtl/coin_input_conditioner_pkg.sv
// Shared definitions for the coin front end and the dispenser: FSM state
// encodings and coin values.
package coin_input_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD_U   = 3'd1,
    ST_HOLD_D   = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_GAP      = 3'd4
  } coin_state_e;

  localparam logic [7:0] COIN_U_VAL = 8'd1;
  localparam logic [7:0] COIN_D_VAL = 8'd2;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce.sv
// coin_debounce: 2-flop synchroniser, stability-counter debounce and a
// registered one-cycle rise event on the filtered level.
module coin_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = filt_q;
  assign rise  = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: debounced coin lines -> exclusive, stretched coin
// strobes with reject pulse. Optional running total under COIN_TOTAL_EN.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned HOLD_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       u_raw,
  input  logic       d_raw,
  output logic       coin_u,
  output logic       coin_d,
  output logic       reject,
  output logic       busy
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0] coin_total
`endif
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  logic u_level, u_rise, d_level, d_rise;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk), .rst(rst), .raw(u_raw), .level(u_level), .rise(u_rise)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) d_deb (
    .clk(clk), .rst(rst), .raw(d_raw), .level(d_level), .rise(d_rise)
  );

  coin_state_e   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          reject_q, reject_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    reject_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (u_rise && d_rise) begin
          reject_d = 1'b1;
          state_d  = ST_WAIT_REL;
        end else if (u_rise) begin
          state_d = ST_HOLD_U;
        end else if (d_rise) begin
          state_d = ST_HOLD_D;
        end
      end
      ST_HOLD_U, ST_HOLD_D: begin
        // Only the other channel can be refused here; the strobe itself runs to completion.
        reject_d = (state_q == ST_HOLD_U) ? d_rise : u_rise;
        if (hold_cnt_q == HOLD_MAX) begin
          hold_cnt_d = '0;
          state_d    = ST_WAIT_REL;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        reject_d   = u_rise | d_rise;
        hold_cnt_d = '0;
        if (!u_level && !d_level) state_d = ST_GAP;
      end
      ST_GAP: begin
        reject_d = u_rise | d_rise;
        if (hold_cnt_q == HOLD_MAX) begin
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        hold_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      reject_q   <= reject_d;
    end
  end

  assign coin_u = (state_q == ST_HOLD_U);
  assign coin_d = (state_q == ST_HOLD_D);
  assign reject = reject_q;
  assign busy   = (state_q != ST_IDLE);

`ifdef COIN_TOTAL_EN
  logic [7:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (state_q == ST_IDLE && state_d == ST_HOLD_U) total_d = sat_add8(total_q, COIN_U_VAL);
    if (state_q == ST_IDLE && state_d == ST_HOLD_D) total_d = sat_add8(total_q, COIN_D_VAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner (DEB_CYCLES=4, HOLD_CYCLES=8);
// total-counter steps are built only when COIN_TOTAL_EN is defined.
module tb_coin_input_conditioner;

  logic clk, rst, u_raw, d_raw;
  logic coin_u, coin_d, reject, busy;
`ifdef COIN_TOTAL_EN
  logic [7:0] coin_total;
`endif

  coin_input_conditioner #(.DEB_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .u_raw(u_raw), .d_raw(d_raw),
    .coin_u(coin_u), .coin_d(coin_d), .reject(reject), .busy(busy)
`ifdef COIN_TOTAL_EN
    , .coin_total(coin_total)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Window statistics, indexed by negedges since the window was cleared.
  int cyc, u_hi, d_hi, u_first, d_first, u_edges, d_edges;
  int rej_n, rej_first, busy_n, both_n;
  logic prev_u, prev_d;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_win();
    cyc = 0; u_hi = 0; d_hi = 0; u_first = -1; d_first = -1;
    u_edges = 0; d_edges = 0; rej_n = 0; rej_first = -1; busy_n = 0; both_n = 0;
    prev_u = 1'b0; prev_d = 1'b0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (coin_u === 1'b1) begin u_hi++; if (u_first < 0) u_first = cyc; if (!prev_u) u_edges++; end
      if (coin_d === 1'b1) begin d_hi++; if (d_first < 0) d_first = cyc; if (!prev_d) d_edges++; end
      if (reject === 1'b1) begin rej_n++; if (rej_first < 0) rej_first = cyc; end
      if (busy === 1'b1) busy_n++;
      if (coin_u === 1'b1 && coin_d === 1'b1) both_n++;
      prev_u = coin_u;
      prev_d = coin_d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; u_raw = 1'b0; d_raw = 1'b0;
    observe(3);
    rst = 1'b0;
    observe(2);
  endtask

`ifdef COIN_TOTAL_EN
  task automatic press(input logic is_d);
    if (is_d) d_raw = 1'b1; else u_raw = 1'b1;
    observe(20);
    u_raw = 1'b0; d_raw = 1'b0;
    observe(30);
  endtask
`endif

  initial begin
    rst = 1'b1; u_raw = 1'b0; d_raw = 1'b0;
    clear_win();
    #1;
    chk("reset_coin_u", coin_u, 0);
    chk("reset_coin_d", coin_d, 0);
    chk("reset_reject", reject, 0);
    chk("reset_busy", busy, 0);
`ifdef COIN_TOTAL_EN
    chk("reset_total", coin_total, 0);
`endif
    observe(3);
    rst = 1'b0;
    observe(2);

    // 1: reset in the middle of a u strobe
    clear_win();
    u_raw = 1'b1;
    observe(10);
    chk("t1_strobe_before_rst", coin_u, 1);
    rst = 1'b1; u_raw = 1'b0;
    #1;
    chk("t1_async_coin_u", coin_u, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_reject", reject, 0);
    observe(3);
    rst = 1'b0;
    clear_win();
    observe(30);
    chk("t1_no_strobe_after", u_hi + d_hi, 0);
    chk("t1_idle_after", busy_n, 0);

    // 2: clean u press held 20 clk
    clear_win();
    u_raw = 1'b1;
    observe(20);
    u_raw = 1'b0;
    observe(30);
    chk("t2_u_first", u_first, 7);
    chk("t2_u_width", u_hi, 8);
    chk("t2_u_strobes", u_edges, 1);
    chk("t2_coin_d", d_hi, 0);
    chk("t2_reject", rej_n, 0);
    chk("t2_busy_cycles", busy_n, 28);

    // 3: bouncing d line, then stable
    clear_win();
    for (int k = 0; k < 6; k++) begin
      d_raw = ~k[0];
      observe(2);
    end
    d_raw = 1'b1;
    observe(20);
    d_raw = 1'b0;
    observe(30);
    chk("t3_d_strobes", d_edges, 1);
    chk("t3_d_first", d_first, 19);
    chk("t3_d_width", d_hi, 8);
    chk("t3_coin_u", u_hi, 0);
    chk("t3_reject", rej_n, 0);

    // 4: simultaneous insert
    clear_win();
    u_raw = 1'b1; d_raw = 1'b1;
    observe(20);
    u_raw = 1'b0; d_raw = 1'b0;
    observe(30);
    chk("t4_reject_count", rej_n, 1);
    chk("t4_reject_at", rej_first, 7);
    chk("t4_no_strobe", u_hi + d_hi, 0);
    chk("t4_busy_cycles", busy_n, 28);
    chk("t4_idle_end", busy, 0);

    // 5: d pressed while the u strobe is active
    clear_win();
    u_raw = 1'b1;
    observe(7);
    d_raw = 1'b1;
    observe(13);
    u_raw = 1'b0; d_raw = 1'b0;
    observe(30);
    chk("t5_u_first", u_first, 7);
    chk("t5_u_width", u_hi, 8);
    chk("t5_reject_count", rej_n, 1);
    chk("t5_reject_at", rej_first, 14);
    chk("t5_no_coin_d", d_hi, 0);
    chk("t5_exclusive", both_n, 0);

`ifdef COIN_TOTAL_EN
    // 6: running total and saturation
    do_reset();
    chk("t6_total_cleared", coin_total, 0);
    for (int k = 0; k < 3; k++) press(1'b0);
    for (int k = 0; k < 2; k++) press(1'b1);
    chk("t6_total_7", coin_total, 7);
    for (int k = 0; k < 123; k++) press(1'b1);
    chk("t6_total_253", coin_total, 253);
    for (int k = 0; k < 7; k++) press(1'b1);
    chk("t6_total_sat", coin_total, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
